paged_rom_access: RTL

//   CPU-side front end for the ROM set. Decodes CPU accesses to &8000-&FFFF and

---
 rtl/paged_rom_access.sv | 108 ++++++++++
 1 files changed

// File: rtl/paged_rom_access.sv
// CPU-side front end for the ROM set: &8000-&FFFF read decode, ROMSEL latch and
// registered-ROM fetch FSM. Optional sideways-RAM write path under `SWRAM_WE_EN.
module paged_rom_access #(
  parameter logic [3:0]  MOS_BANK    = 4'h4,
  parameter logic [11:0] ROMSEL_BASE = 12'hFE3,
  parameter logic [15:0] SWRAM_MASK  = 16'h00C0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_clken,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_dout,
  output logic [17:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  cpu_rom_data,
  output logic        cpu_rom_valid,
  output logic        busy,
  output logic [3:0]  romsel,
  output logic        overrun,
  output logic [1:0]  state_dbg
`ifdef SWRAM_WE_EN
  ,
  output logic        swram_we,
  output logic [7:0]  swram_wdata
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic       idle;
  logic       rd_hit;
  logic       sel_wr;
  logic [3:0] fetch_bank;

  // Handshake: cpu_clken is a single-cycle valid with no ready; requests that
  // arrive while busy are dropped and recorded in the sticky overrun flag.
  assign idle       = (state == IDLE);
  assign rd_hit     = cpu_clken && !cpu_we && cpu_addr[15];
  assign sel_wr     = cpu_clken && cpu_we && (cpu_addr[15:4] == ROMSEL_BASE);
  assign fetch_bank = cpu_addr[14] ? MOS_BANK : romsel;

  assign busy          = !idle;
  assign cpu_rom_valid = (state == DONE);
  assign state_dbg     = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (rd_hit) state_next = ADDR;
      ADDR: state_next = WAIT;
      WAIT: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

`ifdef SWRAM_WE_EN
  logic sw_hit;
  assign sw_hit = cpu_clken && cpu_we && (cpu_addr[15:14] == 2'b10) && SWRAM_MASK[romsel];
`else
  logic unused_mask;
  assign unused_mask = ^SWRAM_MASK;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr     <= '0;
      cpu_rom_data <= 8'hFF;
      romsel       <= '0;
      overrun      <= 1'b0;
`ifdef SWRAM_WE_EN
      swram_we     <= 1'b0;
      swram_wdata  <= '0;
`endif
    end else begin
      // Bank is captured here, so a later ROMSEL write cannot redirect a fetch.
      if (idle && rd_hit)
        rom_addr <= {fetch_bank, cpu_addr[13:0]};
      if (idle && sel_wr)
        romsel <= cpu_dout[3:0];
      if (state == WAIT)
        cpu_rom_data <= rom_data;
      if (busy && cpu_clken)
        overrun <= 1'b1;
`ifdef SWRAM_WE_EN
      swram_we <= idle && sw_hit;
      if (idle && sw_hit) begin
        rom_addr    <= {romsel, cpu_addr[13:0]};
        swram_wdata <= cpu_dout;
      end
`endif
    end
  end

endmodule
